// File: rtl/k12a_alu_flags_chain.sv
// Registered ALU flag unit: derives compare flags from a WIDTH-bit adder slice,
// chains multi-precision chunks and evaluates branch conditions from the flags.
module k12a_alu_flags_chain #(
    parameter int WIDTH      = 8,
    parameter int MAX_CHUNKS = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             op_valid,
    input  logic             op_first,
    input  logic             op_last,
    input  logic             carry_init,
    input  logic             adder_carry_out,
    input  logic [WIDTH-1:0] adder_output,
    input  logic             adder_input1_msb,
    input  logic             adder_input2_msb,
    input  logic             flags_load,
    input  logic [7:0]       flags_load_data,
    input  logic [3:0]       cond_sel,
    output logic             adder_carry_in,
    output logic [7:0]       flags,
    output logic             cond_true,
    output logic             chain_active,
    output logic             protocol_error
);

    localparam int CW = $clog2(MAX_CHUNKS + 1) + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_CHUNKS);

    typedef enum logic {
        IDLE  = 1'b0,
        CHAIN = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    flags_q, flags_d;
    logic          carry_q, carry_d;
    logic          zero_acc_q, zero_acc_d;
    logic          lsb_q, lsb_d;
    logic          perr_q, perr_d;
    logic [CW-1:0] count_q, count_d;

    logic       chunk_zero;
    logic       res_zero;
    logic       res_lsb;
    logic       res_neg;
    logic       res_ovf;
    logic       res_ult;
    logic       res_slt;
    logic [7:0] res_flags;

    // Flag candidates for the chunk on the inputs; only committed on op_last.
    always_comb begin
        chunk_zero = (adder_output == '0);
        res_zero   = chunk_zero & (op_first | zero_acc_q);
        res_lsb    = op_first ? adder_output[0] : lsb_q;
        res_neg    = adder_output[WIDTH-1];
        res_ovf    = (adder_input1_msb ^ res_neg) & (adder_input2_msb ^ res_neg);
        res_ult    = ~adder_carry_out;
        res_slt    = res_neg ^ res_ovf;
        res_flags  = {res_slt | res_zero, res_slt, res_ult | res_zero, res_ult,
                      res_ovf, res_lsb, res_neg, res_zero};
    end

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        carry_d    = carry_q;
        zero_acc_d = zero_acc_q;
        lsb_d      = lsb_q;
        count_d    = count_q;
        perr_d     = perr_q;
        if (flags_load) begin
            flags_d = flags_load_data;
            state_d = IDLE;
            count_d = '0;
        end else if (op_valid) begin
            if (op_first) begin
                // A first chunk always (re)starts an operation, even mid-chain.
                if (op_last) begin
                    flags_d = res_flags;
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    state_d    = CHAIN;
                    count_d    = CW'(1);
                    carry_d    = adder_carry_out;
                    zero_acc_d = res_zero;
                    lsb_d      = res_lsb;
                end
            end else if (state_q == IDLE) begin
                perr_d = 1'b1;
            end else if (count_q >= MAX_CNT) begin
                perr_d  = 1'b1;
                state_d = IDLE;
                count_d = '0;
            end else if (op_last) begin
                flags_d = res_flags;
                state_d = IDLE;
                count_d = '0;
            end else begin
                count_d    = count_q + CW'(1);
                carry_d    = adder_carry_out;
                zero_acc_d = res_zero;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            flags_q    <= 8'h00;
            carry_q    <= 1'b0;
            zero_acc_q <= 1'b1;
            lsb_q      <= 1'b0;
            count_q    <= '0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            flags_q    <= flags_d;
            carry_q    <= carry_d;
            zero_acc_q <= zero_acc_d;
            lsb_q      <= lsb_d;
            count_q    <= count_d;
            perr_q     <= perr_d;
        end
    end

    assign adder_carry_in = ((state_q == IDLE) || op_first) ? carry_init : carry_q;
    assign flags          = flags_q;
    assign cond_true      = flags_q[cond_sel[2:0]] ^ cond_sel[3];
    assign chain_active   = (state_q == CHAIN);
    assign protocol_error = perr_q;

endmodule

// File: tb/tb_k12a_alu_flags_chain.sv
// Bench for k12a_alu_flags_chain: drives a real chunked adder and checks the
// flags against full-precision arithmetic on the whole multi-chunk operands.
module tb_k12a_alu_flags_chain;

    localparam int W    = 8;
    localparam int MAXC = 4;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic         op_valid = 1'b0;
    logic         op_first = 1'b0;
    logic         op_last = 1'b0;
    logic         carry_init = 1'b0;
    logic         adder_carry_out = 1'b0;
    logic [W-1:0] adder_output = '0;
    logic         adder_input1_msb = 1'b0;
    logic         adder_input2_msb = 1'b0;
    logic         flags_load = 1'b0;
    logic [7:0]   flags_load_data = 8'h00;
    logic [3:0]   cond_sel = 4'h0;
    logic         adder_carry_in;
    logic [7:0]   flags;
    logic         cond_true;
    logic         chain_active;
    logic         protocol_error;

    k12a_alu_flags_chain #(.WIDTH(W), .MAX_CHUNKS(MAXC)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .op_valid        (op_valid),
        .op_first        (op_first),
        .op_last         (op_last),
        .carry_init      (carry_init),
        .adder_carry_out (adder_carry_out),
        .adder_output    (adder_output),
        .adder_input1_msb(adder_input1_msb),
        .adder_input2_msb(adder_input2_msb),
        .flags_load      (flags_load),
        .flags_load_data (flags_load_data),
        .cond_sel        (cond_sel),
        .adder_carry_in  (adder_carry_in),
        .flags           (flags),
        .cond_true       (cond_true),
        .chain_active    (chain_active),
        .protocol_error  (protocol_error)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    // Reference model: operands of the current operation accumulated as whole numbers.
    bit              m_active = 0;
    int              m_n = 0;
    longint unsigned m_a = 0;
    longint unsigned m_b2 = 0;
    bit              m_cin0 = 0;
    logic [7:0]      m_flags = 8'h00;
    bit              m_perr = 0;
    logic [7:0]      s_a = 8'h00;
    logic [7:0]      s_b2 = 8'h00;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_cin();
        longint unsigned s;
        if (!m_active || op_first) return carry_init;
        s = m_a + m_b2 + longint'(m_cin0);
        return bit'((s >> (8 * m_n)) & 1);
    endfunction

    function automatic void model_finish();
        int              bits;
        longint unsigned s, mask, res;
        bit              carry, zero, neg, am, bm, ovf, ult, slt;
        bits  = 8 * m_n;
        s     = m_a + m_b2 + longint'(m_cin0);
        mask  = (longint'(1) << bits) - 1;
        res   = s & mask;
        carry = bit'((s >> bits) & 1);
        zero  = (res == 0);
        neg   = bit'((res >> (bits - 1)) & 1);
        am    = bit'((m_a >> (bits - 1)) & 1);
        bm    = bit'((m_b2 >> (bits - 1)) & 1);
        ovf   = (am == bm) && (neg != am);
        ult   = !carry;
        slt   = neg ^ ovf;
        m_flags  = {slt | zero, slt, ult | zero, ult, ovf, bit'(res & 1), neg, zero};
        m_active = 0;
        m_n      = 0;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 0; m_n = 0; m_flags = 8'h00; m_perr = 0;
        end else if (flags_load) begin
            m_flags = flags_load_data; m_active = 0; m_n = 0;
        end else if (op_valid) begin
            if (op_first) begin
                m_a = longint'(s_a); m_b2 = longint'(s_b2); m_cin0 = carry_init;
                m_n = 1; m_active = 1;
                if (op_last) model_finish();
            end else if (!m_active) begin
                m_perr = 1;
            end else if (m_n >= MAXC) begin
                m_perr = 1; m_active = 0; m_n = 0;
            end else begin
                m_a  |= longint'(s_a) << (8 * m_n);
                m_b2 |= longint'(s_b2) << (8 * m_n);
                m_n++;
                if (op_last) model_finish();
            end
        end
    end

    // Single compare process: every output against the model each cycle.
    always @(negedge clock) begin
        if (chk_en) begin
            check("flags", flags, m_flags);
            check("chain_active", {7'd0, chain_active}, {7'd0, m_active});
            check("protocol_error", {7'd0, protocol_error}, {7'd0, m_perr});
            check("cond_true", {7'd0, cond_true}, {7'd0, m_flags[cond_sel[2:0]] ^ cond_sel[3]});
            check("adder_carry_in", {7'd0, adder_carry_in}, {7'd0, model_cin()});
        end
    end

    task automatic do_cycle(input bit v, input bit f, input bit l, input bit sub,
                            input logic [7:0] a, input logic [7:0] b,
                            input bit fl, input logic [7:0] fld);
        logic [8:0] sum;
        @(posedge clock);
        #1;
        op_valid        = v;
        op_first        = f;
        op_last         = l;
        carry_init      = sub;
        flags_load      = fl;
        flags_load_data = fld;
        cond_sel        = 4'($urandom);
        s_a             = a;
        s_b2            = sub ? ~b : b;
        sum             = {1'b0, a} + {1'b0, s_b2} + {8'd0, model_cin()};
        adder_output     = sum[7:0];
        adder_carry_out  = sum[8];
        adder_input1_msb = a[7];
        adder_input2_msb = s_b2[7];
    endtask

    task automatic idle();
        do_cycle(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
    endtask

    task automatic pulse_reset(input bit do_chk);
        @(posedge clock);
        #1;
        op_valid = 0; op_first = 0; op_last = 0; flags_load = 0;
        reset_n = 0;
        #1;
        if (do_chk) begin
            check("async_rst_flags", flags, 8'h00);
            check("async_rst_chain", {7'd0, chain_active}, 8'h00);
            check("async_rst_perr", {7'd0, protocol_error}, 8'h00);
        end
        @(negedge clock);
        #2 reset_n = 1;
    endtask

    initial begin
        bit   v, f, l, fl, cur_sub;
        logic [7:0] a, b;
        cur_sub = 0;
        pulse_reset(0);
        chk_en = 1;

        // 0x05 - 0x07, single chunk
        do_cycle(1, 1, 1, 1, 8'h05, 8'h07, 0, 8'h00);
        idle();
        @(negedge clock);
        check("t1_flags", flags, 8'hF2);
        cond_sel = 4'h4; #1 check("t1_cond4", {7'd0, cond_true}, 8'h01);
        cond_sel = 4'hC; #1 check("t1_condC", {7'd0, cond_true}, 8'h00);

        // 0x1234 - 0x1234
        do_cycle(1, 1, 0, 1, 8'h34, 8'h34, 0, 8'h00);
        @(negedge clock);
        check("t2_chain_pre", {7'd0, chain_active}, 8'h00);
        do_cycle(1, 0, 1, 1, 8'h12, 8'h12, 0, 8'h00);
        @(negedge clock);
        check("t2_chain_mid", {7'd0, chain_active}, 8'h01);
        check("t2_cin", {7'd0, adder_carry_in}, 8'h01);
        idle();
        @(negedge clock);
        check("t2_flags", flags, 8'hA1);
        check("t2_chain_post", {7'd0, chain_active}, 8'h00);

        // 0x0100 - 0x0001
        do_cycle(1, 1, 0, 1, 8'h00, 8'h01, 0, 8'h00);
        do_cycle(1, 0, 1, 1, 8'h01, 8'h00, 0, 8'h00);
        @(negedge clock);
        check("t3_cin", {7'd0, adder_carry_in}, 8'h00);
        idle();
        @(negedge clock);
        check("t3_flags", flags, 8'h04);

        // reset in the middle of a 3-chunk chain
        do_cycle(1, 1, 0, 0, 8'h11, 8'h22, 0, 8'h00);
        do_cycle(1, 0, 0, 0, 8'h33, 8'h44, 0, 8'h00);
        pulse_reset(1);
        do_cycle(1, 1, 1, 1, 8'h05, 8'h07, 0, 8'h00);
        idle();
        @(negedge clock);
        check("t6_flags", flags, 8'hF2);

        // flags_load wins over a first chunk
        do_cycle(1, 1, 0, 0, 8'h10, 8'h20, 1, 8'h5A);
        idle();
        @(negedge clock);
        check("t4_flags", flags, 8'h5A);
        check("t4_chain", {7'd0, chain_active}, 8'h00);
        do_cycle(1, 0, 1, 0, 8'h10, 8'h20, 0, 8'h00);
        idle();
        @(negedge clock);
        check("t4_perr", {7'd0, protocol_error}, 8'h01);
        check("t4_flags_kept", flags, 8'h5A);

        // chunk count overflow
        pulse_reset(0);
        do_cycle(1, 1, 1, 1, 8'h05, 8'h07, 0, 8'h00);
        do_cycle(1, 1, 0, 0, 8'h01, 8'h02, 0, 8'h00);
        for (int i = 0; i < 3; i++) do_cycle(1, 0, 0, 0, 8'h03, 8'h04, 0, 8'h00);
        do_cycle(1, 0, 0, 0, 8'h05, 8'h06, 0, 8'h00);
        @(negedge clock);
        check("t5_perr_pre", {7'd0, protocol_error}, 8'h00);
        check("t5_chain_pre", {7'd0, chain_active}, 8'h01);
        idle();
        @(negedge clock);
        check("t5_perr", {7'd0, protocol_error}, 8'h01);
        check("t5_chain", {7'd0, chain_active}, 8'h00);
        check("t5_flags", flags, 8'hF2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) pulse_reset(0);
            fl = ($urandom_range(0, 99) < 4);
            v  = ($urandom_range(0, 99) < 75);
            f  = m_active ? ($urandom_range(0, 99) < 8) : ($urandom_range(0, 99) < 92);
            l  = ($urandom_range(0, 99) < 30);
            if (f) cur_sub = bit'($urandom_range(0, 1));
            a = 8'($urandom);
            b = ($urandom_range(0, 99) < 35) ? a : 8'($urandom);
            if ($urandom_range(0, 99) < 10) begin a = 8'h00; b = 8'h00; end
            do_cycle(v, f, l, cur_sub, a, b, fl, 8'($urandom));
        end
        idle();
        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
